// File: rtl/pd_reset_ctrl.sv
// USB-PD hard/cable reset transmit controller: drives PHY request/retry sequencing,
// keeps sticky ALERT status and the receive-detect / byte-count register images.
module pd_reset_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ALERT_W     = 16,
  parameter int RETRY_MAX   = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               TX_WR,
  input  logic [DATA_W-1:0]  ioTRANSMIT,
  input  logic               PHY_ACK,
  input  logic               PHY_RX_HARD_RESET,
  input  logic               RX_BYTE,
  input  logic [ALERT_W-1:0] ALERT_CLR,
  output logic [DATA_W-1:0]  oTRANSMIT,
  output logic               PHY_TX_REQ,
  output logic [ALERT_W-1:0] ALERT,
  output logic [DATA_W-1:0]  oRECEIVE_DETECT,
  output logic [DATA_W-1:0]  oRECEIVE_BYTE_COUNT,
  output logic               PHY_Stop_Attempting_Reset,
  output logic               BUSY
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [TW-1:0] TMR_LOAD  = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  localparam logic [2:0]    CMD_HARD  = 3'b101;
  localparam logic [2:0]    CMD_CABLE = 3'b110;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, SUCCESS, FAIL} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tmr_q, tmr_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [DATA_W-1:0]  xmit_q, xmit_d;
  logic [DATA_W-1:0]  det_q, det_d;
  logic [DATA_W-1:0]  cnt_q, cnt_d;
  logic [ALERT_W-1:0] alert_q, alert_d;
  logic [ALERT_W-1:0] set_mask;
  logic               stop_q, stop_d;
  logic               req_q, req_d;
  logic               busy;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    xmit_d   = xmit_q;
    det_d    = det_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    set_mask = '0;

    if (TX_WR && busy) set_mask[5] = 1'b1;
    if (RX_BYTE && !busy && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (TX_WR && ((ioTRANSMIT[2:0] == CMD_HARD) || (ioTRANSMIT[2:0] == CMD_CABLE))) begin
          state_d = SEND;
          xmit_d  = ioTRANSMIT;
          retry_d = '0;
          stop_d  = 1'b0;
        end
      end
      SEND: begin
        tmr_d   = TMR_LOAD;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // The final count cycle still honours a late PHY_ACK.
        if (tmr_q != '0) tmr_d = tmr_q - 1'b1;
        if (PHY_ACK) begin
          state_d = SUCCESS;
        end else if (tmr_q <= TW'(1)) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            state_d = FAIL;
          end
        end
      end
      SUCCESS: begin
        set_mask[6] = 1'b1;
        cnt_d       = '0;
        if (xmit_q[2:0] == CMD_HARD) det_d = '0;
        state_d     = IDLE;
      end
      FAIL: begin
        set_mask[4] = 1'b1;
        stop_d      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A partner hard reset overrides whatever the sequencer was doing.
    if (PHY_RX_HARD_RESET) begin
      state_d     = IDLE;
      xmit_d      = xmit_q;
      stop_d      = stop_q;
      set_mask[4] = 1'b0;
      set_mask[6] = 1'b0;
      set_mask[3] = 1'b1;
      det_d       = '0;
      cnt_d       = '0;
    end

    req_d   = (state_d == SEND);
    alert_d = (alert_q & ~ALERT_CLR) | set_mask;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      retry_q <= '0;
      xmit_q  <= '0;
      det_q   <= '1;
      cnt_q   <= '0;
      alert_q <= '0;
      stop_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      xmit_q  <= xmit_d;
      det_q   <= det_d;
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
      stop_q  <= stop_d;
      req_q   <= req_d;
    end
  end

  assign oTRANSMIT                 = xmit_q;
  assign PHY_TX_REQ                = req_q;
  assign ALERT                     = alert_q;
  assign oRECEIVE_DETECT           = det_q;
  assign oRECEIVE_BYTE_COUNT       = cnt_q;
  assign PHY_Stop_Attempting_Reset = stop_q;
  assign BUSY                      = busy;

endmodule
